// File: rtl/csr_pkg.sv
// CSR address map, funct3 encodings and shared helpers.
// Read-modify-write math is done at a fixed 64-bit width.
package csr_pkg;

  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam int RMW_W = 64;

  function automatic logic [RMW_W-1:0] csr_rmw(
    input logic [2:0]       op,
    input logic [RMW_W-1:0] cur,
    input logic [RMW_W-1:0] src
  );
    logic [RMW_W-1:0] res;
    case (op)
      F3_RW, F3_RWI: res = src;
      F3_RS, F3_RSI: res = cur | src;
      F3_RC, F3_RCI: res = cur & ~src;
      default:       res = cur;
    endcase
    return res;
  endfunction

  // set/clear with a zero mask are reads only
  function automatic logic csr_wr(
    input logic [2:0] op,
    input logic       src_nz
  );
    logic res;
    case (op)
      F3_RW, F3_RWI: res = 1'b1;
      F3_RS, F3_RSI,
      F3_RC, F3_RCI: res = src_nz;
      default:       res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [11:0] csr_canon(
    input logic [11:0] a
  );
    logic [11:0] res;
    case (a)
      CSR_CYCLE:    res = CSR_MCYCLE;
      CSR_INSTRET:  res = CSR_MINSTRET;
      CSR_CYCLEH:   res = CSR_MCYCLEH;
      CSR_INSTRETH: res = CSR_MINSTRETH;
      default:      res = a;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_file_unit_if.sv
// ID read port and WB commit port of the CSR unit.
// master = pipeline side, slave = CSR unit.
interface csr_file_unit_if #(
  parameter int XLEN = 32
);
  logic [11:0]     rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            rd_illegal;
  logic            wb_en;
  logic [11:0]     wb_addr;
  logic [2:0]      wb_op;
  logic [XLEN-1:0] wb_src;
  logic            retire;
  logic            wb_illegal;

  modport master (
    output rd_addr, wb_en, wb_addr,
    output wb_op, wb_src, retire,
    input  rd_data, rd_illegal, wb_illegal
  );

  modport slave (
    input  rd_addr, wb_en, wb_addr,
    input  wb_op, wb_src, retire,
    output rd_data, rd_illegal, wb_illegal
  );
endinterface

// File: rtl/csr_counter.sv
// Free-running counter with independent low/high half writes.
// A write overrides the increment for the half it targets.
module csr_counter #(
  parameter int CNT_W = 64,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [XLEN-1:0]  wdata,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] r_val;
  logic [CNT_W-1:0] w_sum;
  logic [CNT_W-1:0] w_nxt;

  assign w_sum = r_val + CNT_W'(inc);

  generate
    if (CNT_W > XLEN) begin : g_split
      // hi write drops the carry out of lo
      always_comb begin
        w_nxt = w_sum;
        if (wr_lo)
          w_nxt = {r_val[CNT_W-1:XLEN], wdata};
        else if (wr_hi)
          w_nxt = {wdata, w_sum[XLEN-1:0]};
      end
    end else begin : g_flat
      logic w_unused_hi;
      assign w_unused_hi = wr_hi;
      always_comb begin
        w_nxt = wr_lo ? wdata : w_sum;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst)
      r_val <= '0;
    else
      r_val <= w_nxt;
  end

  assign value = r_val;

endmodule

// File: rtl/csr_file_unit.sv
// CSR storage, RMW ALU, counters and WB->ID bypass.
// Read is combinational from ID, commit is at the WB clock edge.
module csr_file_unit
  import csr_pkg::*;
#(
  parameter int          XLEN    = 32,
  parameter int          NUM_CSR = 8,
  parameter logic [11:0] GP_BASE = 12'h340,
  parameter int          CNT_W   = 64
) (
  input  logic          clk,
  input  logic          rst,
  csr_file_unit_if.slave bus
);

  localparam bit HAS_H = (CNT_W > XLEN);

  logic [XLEN-1:0]  r_gp [NUM_CSR];
  logic             r_ill;

  logic [CNT_W-1:0] w_cyc;
  logic [CNT_W-1:0] w_ins;
  logic [XLEN-1:0]  w_cyc_lo;
  logic [XLEN-1:0]  w_cyc_hi;
  logic [XLEN-1:0]  w_ins_lo;
  logic [XLEN-1:0]  w_ins_hi;

  assign w_cyc_lo = w_cyc[XLEN-1:0];
  assign w_ins_lo = w_ins[XLEN-1:0];

  generate
    if (HAS_H) begin : g_hi
      assign w_cyc_hi = w_cyc[CNT_W-1:XLEN];
      assign w_ins_hi = w_ins[CNT_W-1:XLEN];
    end else begin : g_nohi
      assign w_cyc_hi = '0;
      assign w_ins_hi = '0;
    end
  endgenerate

  // returns {mapped, read_only, value}
  function automatic logic [XLEN+1:0] look(
    input logic [11:0] a
  );
    logic            m;
    logic            ro;
    logic [XLEN-1:0] v;
    m  = 1'b0;
    ro = 1'b0;
    v  = '0;
    for (int i = 0; i < NUM_CSR; i++) begin
      if (a == GP_BASE + 12'(i)) begin
        m = 1'b1;
        v = r_gp[i];
      end
    end
    case (a)
      CSR_MCYCLE: begin
        m = 1'b1; v = w_cyc_lo;
      end
      CSR_MINSTRET: begin
        m = 1'b1; v = w_ins_lo;
      end
      CSR_CYCLE: begin
        m = 1'b1; ro = 1'b1; v = w_cyc_lo;
      end
      CSR_INSTRET: begin
        m = 1'b1; ro = 1'b1; v = w_ins_lo;
      end
      CSR_MCYCLEH: begin
        m = HAS_H; v = w_cyc_hi;
      end
      CSR_MINSTRETH: begin
        m = HAS_H; v = w_ins_hi;
      end
      CSR_CYCLEH: begin
        m = HAS_H; ro = 1'b1; v = w_cyc_hi;
      end
      CSR_INSTRETH: begin
        m = HAS_H; ro = 1'b1; v = w_ins_hi;
      end
      default: ;
    endcase
    if (!m) v = '0;
    return {m, ro, v};
  endfunction

  logic [XLEN+1:0]  w_rd_lk;
  logic [XLEN+1:0]  w_wb_lk;
  logic [XLEN-1:0]  w_wb_cur;
  logic [RMW_W-1:0] w_rmw;
  logic [XLEN-1:0]  w_wb_new;
  logic             w_wr;
  logic             w_legal;
  logic             w_commit;
  logic             w_ill;
  logic             w_byp;
  logic             w_unused;

  assign w_rd_lk  = look(bus.rd_addr);
  assign w_wb_lk  = look(bus.wb_addr);
  assign w_wb_cur = w_wb_lk[XLEN-1:0];

  assign w_rmw = csr_rmw(bus.wb_op,
                         RMW_W'(w_wb_cur),
                         RMW_W'(bus.wb_src));
  assign w_wb_new = w_rmw[XLEN-1:0];

  assign w_wr = bus.wb_en
              & csr_wr(bus.wb_op, |bus.wb_src);
  assign w_legal  = w_wb_lk[XLEN+1] & ~w_wb_lk[XLEN];
  assign w_commit = w_wr & w_legal;
  assign w_ill    = w_wr & ~w_legal;

  // aliases fold onto their machine-mode twin
  assign w_byp = w_commit
    & (csr_canon(bus.rd_addr) == bus.wb_addr);

  assign bus.rd_data = w_byp ? w_wb_new
                             : w_rd_lk[XLEN-1:0];
  assign bus.rd_illegal = ~w_rd_lk[XLEN+1];
  assign bus.wb_illegal = r_ill;

  assign w_unused = ^{w_rmw, w_rd_lk[XLEN]};

  always_ff @(posedge clk) begin
    if (!rst)
      r_ill <= 1'b0;
    else
      r_ill <= w_ill;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CSR; i++)
        r_gp[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CSR; i++)
        if (w_commit
            && bus.wb_addr == GP_BASE + 12'(i))
          r_gp[i] <= w_wb_new;
    end
  end

  csr_counter #(
    .CNT_W (CNT_W),
    .XLEN  (XLEN)
  ) u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (w_commit
            && bus.wb_addr == CSR_MCYCLE),
    .wr_hi (w_commit
            && bus.wb_addr == CSR_MCYCLEH),
    .wdata (w_wb_new),
    .value (w_cyc)
  );

  csr_counter #(
    .CNT_W (CNT_W),
    .XLEN  (XLEN)
  ) u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.retire),
    .wr_lo (w_commit
            && bus.wb_addr == CSR_MINSTRET),
    .wr_hi (w_commit
            && bus.wb_addr == CSR_MINSTRETH),
    .wdata (w_wb_new),
    .value (w_ins)
  );

endmodule
